// File: rtl/mnist_bnn_pkg.sv
// Shared definitions for the MNIST binarized-network datapath.
//   IMG_DIM        image side in pixels (rows and row width)
//   BUS_W          pixels carried per input beat
//   IMG_PIXELS     total pixels per image
//   loader_state_t image loader FSM states
package mnist_bnn_pkg;

  localparam int IMG_DIM    = 28;
  localparam int BUS_W      = 8;
  localparam int IMG_PIXELS = IMG_DIM * IMG_DIM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } loader_state_t;

endpackage

// File: rtl/mnist_image_loader.sv
// mnist_image_loader
// Receives one binarized 28x28 image as packed beats (BUS_W pixels per beat,
// bit i = pixel beat*BUS_W+i), stores it in a flop buffer and flags load_done.
// Layer 1 reads the buffer one row per cycle through a registered read port.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   start      begin or restart a load (level)
//   in_valid   in_data holds a beat
//   in_data    packed pixels
//   in_ready   a beat is accepted this cycle when in_valid is also high
//   load_done  whole image stored; held until next start
//   rd_row     row to read, 0..IMG_DIM-1 (out of range reads return 0)
//   rd_data    row pixels, bit c = column c, one cycle after rd_row
//   err        checksum mismatch, sticky until next start (0 without checksum)
//
// Build option: define LOADER_CHECKSUM_EN to append a checksum beat carrying
// the XOR of all data beats; a mismatch drops back to IDLE with err set.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; no beats accepted
// LOAD  | accepting image beats into the buffer
// CHK   | accepting the checksum beat (LOADER_CHECKSUM_EN builds only)
// DONE  | image complete, load_done high, further beats ignored
module mnist_image_loader
  import mnist_bnn_pkg::*;
#(
  parameter int IMG_DIM    = mnist_bnn_pkg::IMG_DIM,
  parameter int BUS_W      = mnist_bnn_pkg::BUS_W,
  parameter int IMG_PIXELS = mnist_bnn_pkg::IMG_PIXELS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [BUS_W-1:0]   in_data,
  output logic               in_ready,
  output logic               load_done,
  input  logic [4:0]         rd_row,
  output logic [IMG_DIM-1:0] rd_data,
  output logic               err
);

  localparam int NUM_BEATS = IMG_PIXELS / BUS_W;

  loader_state_t         state;
  logic [6:0]            beat_cnt;
  logic [IMG_PIXELS-1:0] pix_buf;
  logic [IMG_DIM-1:0]    row_sel;
  logic                  accept;

  // A start cycle never accepts data, whatever the state.
  assign in_ready  = ((state == LOAD) || (state == CHK)) && !start;
  assign accept    = in_valid && in_ready;
  assign load_done = (state == DONE);

  // Constant-index row mux keeps every slice in range; rows past the image read 0.
  always_comb begin
    row_sel = '0;
    for (int r = 0; r < IMG_DIM; r++) begin
      if (rd_row == 5'(r)) row_sel = pix_buf[r*IMG_DIM +: IMG_DIM];
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [BUS_W-1:0] chk_acc;
  logic             chk_match;

  assign chk_match = (in_data == chk_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_acc <= '0;
      err     <= 1'b0;
    end else if (start) begin
      chk_acc <= '0;
      err     <= 1'b0;
    end else if (accept && (state == LOAD)) begin
      chk_acc <= chk_acc ^ in_data;
    end else if (accept && (state == CHK) && !chk_match) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      pix_buf  <= '0;
      rd_data  <= '0;
    end else begin
      // Read samples the buffer before this cycle's write lands.
      rd_data <= row_sel;
      if (start) begin
        state    <= LOAD;
        beat_cnt <= '0;
      end else if (accept && (state == LOAD)) begin
        for (int b = 0; b < NUM_BEATS; b++) begin
          if (beat_cnt == 7'(b)) pix_buf[b*BUS_W +: BUS_W] <= in_data;
        end
        beat_cnt <= beat_cnt + 7'd1;
        if (beat_cnt == 7'(NUM_BEATS - 1)) begin
`ifdef LOADER_CHECKSUM_EN
          state <= CHK;
`else
          state <= DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      else if (accept && (state == CHK)) begin
        state <= chk_match ? DONE : IDLE;
      end
`endif
    end
  end

endmodule
